// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block and the digit counter.
// Holds the FSM state encoding, the default clock and tick rates, and the
// helpers that derive the prescaler divide ratio and the counter widths.
package stopwatch_pkg;

    localparam int unsigned CLK_HZ_DEF  = 50_000_000;
    localparam int unsigned TICK_HZ_DEF = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } sw_state_e;

    // Clock cycles per tick; the caller guarantees the result is >= 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed for a counter that runs 0..n-1 (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debouncer and press pulse.
// Ports:
//   clk_in  - system clock
//   rst     - synchronous active-high reset
//   btn_n   - raw active-low button, asynchronous to clk_in
//   press   - one-cycle pulse when the debounced level goes released->pressed
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          lvl;      // debounced level, 1 = released
    logic          armed;    // a genuine released sample has been seen since reset
    logic [1:0]    vld;      // marks when sync2 carries post-reset data
    logic [CW-1:0] cnt;

    // Synchronize, count consecutive differing samples, flip the level.
    // A button held through reset is never armed until it is seen released,
    // so no press event can come out of reset release.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            lvl   <= 1'b1;
            armed <= 1'b0;
            vld   <= 2'b00;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            press <= 1'b0;
            if (vld[1] && sync2) begin
                armed <= 1'b1;
            end
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt   <= '0;
                lvl   <= sync2;
                press <= ~sync2 & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: debounces start/clear/lap buttons, runs the
// start/pause/clear/lap FSM and generates tick, clr and freeze for the
// six-digit counter/display datapath.
// Build option: define LAP_EN to enable the lap button and LAP state;
// without it btn_lap_n is ignored and freeze stays 0.
// Ports:
//   clk_in      - system clock
//   rst         - synchronous active-high reset
//   btn_start_n - raw start/pause button (active-low)
//   btn_clear_n - raw clear button (active-low)
//   btn_lap_n   - raw lap button (active-low)
//   tick        - one-cycle counter advance enable, CLK_HZ/TICK_HZ period
//   clr         - one-cycle counter zero pulse
//   freeze      - display hold level while in LAP
//   running     - 1 in RUNNING or LAP
//   state       - current FSM state encoding
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ   = TICK_HZ_DEF,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
    input  logic       btn_lap_n,
    output logic       tick,
    output logic       clr,
    output logic       freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PW  = cnt_width(DIV);

    logic          start_ev;
    logic          clear_ev;
    logic          lap_ev;
    sw_state_e     state_q;
    sw_state_e     state_nx;
    logic          clr_nx;
    logic          running_nx;
    logic          freeze_nx;
    logic [PW-1:0] presc_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n  (btn_start_n),
        .press  (start_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n  (btn_clear_n),
        .press  (clear_ev)
    );

`ifdef LAP_EN
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_n  (btn_lap_n),
        .press  (lap_ev)
    );
`else
    logic unused_lap;
    assign unused_lap = btn_lap_n;
    assign lap_ev     = 1'b0;
`endif

    // State register; level outputs are registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            clr     <= 1'b0;
            running <= 1'b0;
            freeze  <= 1'b0;
        end else begin
            state_q <= state_nx;
            clr     <= clr_nx;
            running <= running_nx;
            freeze  <= freeze_nx;
        end
    end

    assign state = state_q;

    // Next state; one event per cycle with priority start > clear > lap.
    always_comb begin
        state_nx = state_q;
        clr_nx   = 1'b0;
        if (start_ev) begin
            case (state_q)
                IDLE:    state_nx = RUNNING;
                RUNNING: state_nx = PAUSED;
                PAUSED:  state_nx = RUNNING;
                LAP:     state_nx = PAUSED;
                default: state_nx = IDLE;
            endcase
        end else if (clear_ev) begin
            if (state_q == IDLE) begin
                clr_nx = 1'b1;
            end else if (state_q == PAUSED) begin
                state_nx = IDLE;
                clr_nx   = 1'b1;
            end
        end else if (lap_ev) begin
            if (state_q == RUNNING) begin
                state_nx = LAP;
            end else if (state_q == LAP) begin
                state_nx = RUNNING;
            end
        end
    end

    // Output decode from the next state.
    always_comb begin
        running_nx = (state_nx == RUNNING) || (state_nx == LAP);
`ifdef LAP_EN
        freeze_nx  = (state_nx == LAP);
`else
        freeze_nx  = 1'b0;
`endif
    end

    // Tick prescaler; holds in PAUSED so resume keeps the sub-tick phase.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr_nx) begin
                presc_q <= '0;
            end else if ((state_q == RUNNING) || (state_q == LAP)) begin
                if (presc_q == PW'(DIV - 1)) begin
                    presc_q <= '0;
                    tick    <= 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

endmodule
